// File: rtl/pipeline_exec_ctrl_if.sv
// Command/status bundle between the debug front-end and the pipeline execution controller.
interface pipeline_exec_ctrl_if #(
    parameter int CNTBITS = 32
);
    logic               i_cmd_run;
    logic               i_cmd_step;
    logic               i_cmd_stop;
    logic               i_cmd_clear;
    logic               i_halt;
    logic               o_pipe_enable;
    logic               o_busy;
    logic               o_done;
    logic               o_step_ack;
    logic               o_pipe_clear;
    logic [2:0]         o_state;
    logic [CNTBITS-1:0] o_cycle_count;

    modport slave (
        input  i_cmd_run, i_cmd_step, i_cmd_stop, i_cmd_clear, i_halt,
        output o_pipe_enable, o_busy, o_done, o_step_ack, o_pipe_clear,
        output o_state, o_cycle_count
    );

    modport master (
        output i_cmd_run, i_cmd_step, i_cmd_stop, i_cmd_clear, i_halt,
        input  o_pipe_enable, o_busy, o_done, o_step_ack, o_pipe_clear,
        input  o_state, o_cycle_count
    );
endinterface

// File: rtl/pipeline_exec_ctrl.sv
// Whole-pipeline execution sequencer: idle / free-run / single-step / post-HALT drain.
// Its enable is ANDed downstream with hazard stalls, so it never forces progress.
module pipeline_exec_ctrl #(
    parameter int CNTBITS      = 32,
    parameter int DRAIN_CYCLES = 4
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    pipeline_exec_ctrl_if.slave  bus
);
    localparam int DCW = $clog2(DRAIN_CYCLES + 1);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_RUN   = 3'd1;
    localparam logic [2:0] ST_STEP  = 3'd2;
    localparam logic [2:0] ST_DRAIN = 3'd3;
    localparam logic [2:0] ST_DONE  = 3'd4;

    logic [2:0]         state_q, state_d;
    logic [DCW-1:0]     drain_q, drain_d;
    logic [CNTBITS-1:0] cnt_q, cnt_d;
    logic               pipe_clear_q, pipe_clear_d;
    logic               enable;

    always_comb begin
        enable = (state_q == ST_RUN) || (state_q == ST_STEP) || (state_q == ST_DRAIN);
    end

    always_comb begin
        state_d      = state_q;
        drain_d      = drain_q;
        pipe_clear_d = 1'b0;
        cnt_d        = cnt_q;
        // Saturating count of enabled cycles; a clear below overrides it.
        if (enable && (cnt_q != {CNTBITS{1'b1}})) begin
            cnt_d = cnt_q + CNTBITS'(1);
        end

        case (state_q)
            ST_IDLE: begin
                if (bus.i_cmd_clear) begin
                    pipe_clear_d = 1'b1;
                    cnt_d        = '0;
                end else if (bus.i_cmd_run) begin
                    state_d = ST_RUN;
                end else if (bus.i_cmd_step) begin
                    state_d = ST_STEP;
                end
            end
            ST_RUN: begin
                if (bus.i_halt) begin
                    state_d = ST_DRAIN;
                    drain_d = DCW'(DRAIN_CYCLES);
                end else if (bus.i_cmd_stop) begin
                    state_d = ST_IDLE;
                end
            end
            ST_STEP: begin
                if (bus.i_halt) begin
                    state_d = ST_DRAIN;
                    drain_d = DCW'(DRAIN_CYCLES);
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_DRAIN: begin
                // Counter holds the enabled cycles still owed, including this one.
                if (drain_q <= DCW'(1)) begin
                    state_d = ST_DONE;
                    drain_d = '0;
                end else begin
                    drain_d = drain_q - DCW'(1);
                end
            end
            ST_DONE: begin
                if (bus.i_cmd_clear) begin
                    state_d      = ST_IDLE;
                    pipe_clear_d = 1'b1;
                    cnt_d        = '0;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q      <= ST_IDLE;
            drain_q      <= '0;
            cnt_q        <= '0;
            pipe_clear_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            drain_q      <= drain_d;
            cnt_q        <= cnt_d;
            pipe_clear_q <= pipe_clear_d;
        end
    end

    assign bus.o_pipe_enable = enable;
    assign bus.o_busy        = enable;
    assign bus.o_done        = (state_q == ST_DONE);
    assign bus.o_step_ack    = (state_q == ST_STEP);
    assign bus.o_pipe_clear  = pipe_clear_q;
    assign bus.o_state       = state_q;
    assign bus.o_cycle_count = cnt_q;
endmodule

// File: tb/tb_pipeline_exec_ctrl.sv
// Scoreboard bench: stimulus queues per-cycle expected status, a negedge monitor pops and compares.
module tb_pipeline_exec_ctrl;
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_RUN   = 3'd1;
    localparam logic [2:0] S_STEP  = 3'd2;
    localparam logic [2:0] S_DRAIN = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   passes = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    pipeline_exec_ctrl_if #(.CNTBITS(32)) bus0();
    pipeline_exec_ctrl_if #(.CNTBITS(4))  bus1();

    pipeline_exec_ctrl #(.CNTBITS(32), .DRAIN_CYCLES(4)) dut0 (
        .i_clk(clk), .i_rst_n(rst_n), .bus(bus0)
    );
    pipeline_exec_ctrl #(.CNTBITS(4), .DRAIN_CYCLES(4)) dut1 (
        .i_clk(clk), .i_rst_n(rst_n), .bus(bus1)
    );

    typedef struct {
        int         cyc;
        int         dut;
        string      name;
        logic [2:0] st;
        logic       clr;
        int         cnt;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_now(input int d, input string nm, input logic [2:0] st,
                              input logic clr, input int cnt);
        exp_t e;
        e.cyc = cyc; e.dut = d; e.name = nm; e.st = st; e.clr = clr; e.cnt = cnt;
        exp_q.push_back(e);
    endtask

    task automatic zero0();
        bus0.i_cmd_run = 0; bus0.i_cmd_step = 0; bus0.i_cmd_stop = 0;
        bus0.i_cmd_clear = 0; bus0.i_halt = 0;
    endtask

    // Monitor: compare status vector {state,en,busy,done,ack,clr} and counter.
    always @(negedge clk) begin
        while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
            logic [7:0] act_v, exp_v;
            int         act_c;
            logic       e_en;
            mon_e = exp_q.pop_front();
            e_en  = (mon_e.st == S_RUN) || (mon_e.st == S_STEP) || (mon_e.st == S_DRAIN);
            exp_v = {mon_e.st, e_en, e_en, mon_e.st == S_DONE, mon_e.st == S_STEP, mon_e.clr};
            if (mon_e.dut == 0) begin
                act_v = {bus0.o_state, bus0.o_pipe_enable, bus0.o_busy, bus0.o_done,
                         bus0.o_step_ack, bus0.o_pipe_clear};
                act_c = int'(bus0.o_cycle_count);
            end else begin
                act_v = {bus1.o_state, bus1.o_pipe_enable, bus1.o_busy, bus1.o_done,
                         bus1.o_step_ack, bus1.o_pipe_clear};
                act_c = int'({28'd0, bus1.o_cycle_count});
            end
            checks++;
            if (mon_e.cyc != cyc) begin
                $display("FAIL %s: expectation for cycle %0d reached monitor at cycle %0d",
                         mon_e.name, mon_e.cyc, cyc);
            end else if (act_v !== exp_v || act_c != mon_e.cnt) begin
                $display("FAIL %s: st/en/busy/done/ack/clr=%b cnt=%0d, expected %b cnt=%0d",
                         mon_e.name, act_v, act_c, exp_v, mon_e.cnt);
            end else begin
                passes++;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        zero0();
        bus1.i_cmd_run = 0; bus1.i_cmd_step = 0; bus1.i_cmd_stop = 0;
        bus1.i_cmd_clear = 0; bus1.i_halt = 0;

        tick(); tick();
        expect_now(0, "reset_hold", S_IDLE, 0, 0);
        expect_now(1, "reset_hold1", S_IDLE, 0, 0);
        rst_n = 1;
        tick();
        expect_now(0, "reset_release", S_IDLE, 0, 0);

        // Three isolated step pulses, three clocks apart
        for (int k = 0; k < 3; k++) begin
            bus0.i_cmd_step = 1; tick(); bus0.i_cmd_step = 0;
            expect_now(0, "step_cycle", S_STEP, 0, k);
            tick();
            expect_now(0, "step_return", S_IDLE, 0, k + 1);
            tick();
        end
        expect_now(0, "step_count", S_IDLE, 0, 3);

        bus0.i_halt = 1; bus0.i_cmd_stop = 1; tick(); zero0();
        expect_now(0, "idle_ignores_halt_stop", S_IDLE, 0, 3);

        bus0.i_cmd_clear = 1; bus0.i_cmd_run = 1; tick(); zero0();
        expect_now(0, "clear_beats_run", S_IDLE, 1, 0);
        tick();
        expect_now(0, "clear_pulse_end", S_IDLE, 0, 0);

        // Free run, stop sampled on the 10th enabled edge
        bus0.i_cmd_run = 1; tick(); zero0();
        expect_now(0, "run_enter", S_RUN, 0, 0);
        repeat (8) tick();
        expect_now(0, "run_mid", S_RUN, 0, 8);
        tick();
        bus0.i_cmd_stop = 1; tick(); zero0();
        expect_now(0, "run_stop", S_IDLE, 0, 10);

        // Halt on the 7th enabled edge, stop held through drain
        bus0.i_cmd_clear = 1; tick(); zero0();
        expect_now(0, "clear2", S_IDLE, 1, 0);
        bus0.i_cmd_run = 1; tick(); zero0();
        repeat (6) tick();
        bus0.i_halt = 1; tick(); zero0();
        expect_now(0, "halt_to_drain", S_DRAIN, 0, 7);
        bus0.i_cmd_stop = 1;
        tick(); tick();
        expect_now(0, "drain_ignores_stop", S_DRAIN, 0, 9);
        tick();
        expect_now(0, "drain_last", S_DRAIN, 0, 10);
        tick(); zero0();
        expect_now(0, "drain_done", S_DONE, 0, 11);

        bus0.i_cmd_run = 1; tick(); zero0();
        expect_now(0, "done_ignores_run", S_DONE, 0, 11);
        bus0.i_cmd_step = 1; tick(); zero0();
        expect_now(0, "done_ignores_step", S_DONE, 0, 11);
        bus0.i_cmd_clear = 1; tick(); zero0();
        expect_now(0, "done_clear", S_IDLE, 1, 0);
        tick();
        expect_now(0, "clear_single_pulse", S_IDLE, 0, 0);

        // Run+step tie, halt during STEP, halt+stop in RUN
        bus0.i_cmd_run = 1; bus0.i_cmd_step = 1; tick(); zero0();
        expect_now(0, "run_wins_tie", S_RUN, 0, 0);
        bus0.i_cmd_stop = 1; tick(); zero0();
        expect_now(0, "tie_stop", S_IDLE, 0, 1);
        bus0.i_cmd_clear = 1; tick(); zero0();
        bus0.i_cmd_step = 1; tick(); zero0();
        expect_now(0, "step2", S_STEP, 0, 0);
        bus0.i_halt = 1; tick(); zero0();
        expect_now(0, "step_halt", S_DRAIN, 0, 1);
        repeat (3) tick();
        expect_now(0, "step_drain_tail", S_DRAIN, 0, 4);
        tick();
        expect_now(0, "step_drain_done", S_DONE, 0, 5);
        bus0.i_cmd_clear = 1; tick(); zero0();
        bus0.i_cmd_run = 1; tick(); zero0();
        expect_now(0, "run3", S_RUN, 0, 0);
        bus0.i_halt = 1; bus0.i_cmd_stop = 1; tick(); zero0();
        expect_now(0, "halt_beats_stop", S_DRAIN, 0, 1);

        // Asynchronous reset in the middle of a drain
        tick();
        rst_n = 0;
        expect_now(0, "async_reset", S_IDLE, 0, 0);
        tick();
        rst_n = 1;
        tick();
        expect_now(0, "post_reset", S_IDLE, 0, 0);

        // Saturation on the 4-bit counter instance
        bus1.i_cmd_run = 1; tick(); bus1.i_cmd_run = 0;
        expect_now(1, "sat_enter", S_RUN, 0, 0);
        repeat (15) tick();
        expect_now(1, "sat_reach", S_RUN, 0, 15);
        repeat (5) tick();
        expect_now(1, "sat_hold", S_RUN, 0, 15);
        bus1.i_cmd_stop = 1; tick(); bus1.i_cmd_stop = 0;
        expect_now(1, "sat_stop", S_IDLE, 0, 15);

        @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            checks++;
            $display("FAIL scoreboard_drain: %0d expectations left unchecked, expected 0",
                     exp_q.size());
        end
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
